// File: rtl/y_demux4_reg_pkg.sv
// Shared definitions for the y_demux4_reg router: lane geometry, default widths,
// lane index constants and the select decoder.
package y_demux4_reg_pkg;

  localparam int LANES     = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_SIZE  = 32;
  localparam int DEF_CNT_W = 8;

  localparam logic [SEL_W-1:0] LANE0 = 2'd0;
  localparam logic [SEL_W-1:0] LANE1 = 2'd1;
  localparam logic [SEL_W-1:0] LANE2 = 2'd2;
  localparam logic [SEL_W-1:0] LANE3 = 2'd3;

  function automatic logic [LANES-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    sel_decode      = '0;
    sel_decode[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/y_demux4_reg_lane.sv
// One output lane of the router: a single-entry word buffer with its valid flag
// and a wrapping count of words handed to the consumer.
module y_demux_lane #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SIZE-1:0]  data_in,
  input  logic             ready,
  output logic             valid,
  output logic [SIZE-1:0]  data_out,
  output logic [CNT_W-1:0] count
);

  logic deliver;

  assign deliver = valid & ready;

  // A load wins over a delivery so a same-cycle refill keeps the lane valid;
  // data is only ever written on a load, so it stays frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      data_out <= '0;
      count    <= '0;
    end else begin
      if (load) begin
        valid    <= 1'b1;
        data_out <= data_in;
      end else if (deliver) begin
        valid <= 1'b0;
      end
      if (deliver) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/y_demux4_reg.sv
// Registered 1-to-4 demultiplexer: steers each accepted word into the one-entry
// buffer of the lane chosen by in_sel and exposes all lanes side by side.
module y_demux4_reg
  import y_demux4_reg_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIZE-1:0]        in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*SIZE-1:0]  out_data,
  output logic [LANES*CNT_W-1:0] out_count
);

  logic [LANES-1:0] lane_sel;
  logic [LANES-1:0] load;

  assign lane_sel = sel_decode(in_sel);

  // Only the addressed lane can stall the producer; it frees up either when
  // empty or when its consumer drains it in this same cycle.
  always_comb begin
    in_ready = 1'b1;
    unique case (in_sel)
      LANE0:   in_ready = ~out_valid[0] | out_ready[0];
      LANE1:   in_ready = ~out_valid[1] | out_ready[1];
      LANE2:   in_ready = ~out_valid[2] | out_ready[2];
      LANE3:   in_ready = ~out_valid[3] | out_ready[3];
      default: in_ready = 1'b1;
    endcase
  end

  assign load = lane_sel & {LANES{in_valid & in_ready}};

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    y_demux_lane #(
      .SIZE (SIZE),
      .CNT_W(CNT_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[k]),
      .data_in (in_data),
      .ready   (out_ready[k]),
      .valid   (out_valid[k]),
      .data_out(out_data[k*SIZE +: SIZE]),
      .count   (out_count[k*CNT_W +: CNT_W])
    );
  end

endmodule
